// File: rtl/mul_issue_arb_pkg.sv
// Shared types for the multiplier issue arbiter: the queued request record
// and the round-robin pick helper.
package mul_issue_arb_pkg;

  localparam int NUM_MUL_PORTS = 2;
  localparam int PKG_M_WIDTH   = 64;
  localparam int PKG_LG_ROB    = 6;
  localparam int PKG_LG_PRF    = 7;

  typedef struct packed {
    logic                   is_signed;
    logic                   is_high;
    logic                   is_mulw;
    logic [PKG_M_WIDTH-1:0] src_A;
    logic [PKG_M_WIDTH-1:0] src_B;
    logic [PKG_LG_ROB-1:0]  rob_ptr;
    logic [PKG_LG_PRF-1:0]  prf_ptr;
  } mul_req_t;

  // Single candidate wins outright; on a tie the RR pointer decides.
  function automatic logic rr_pick(input logic [NUM_MUL_PORTS-1:0] cand, input logic rr);
    if (cand == 2'b11) return rr;
    return cand[1] & ~cand[0];
  endfunction

endpackage

// File: rtl/mul_issue_arb_fifo.sv
// Small request FIFO; pointers carry one extra wrap bit to separate full from empty.
module mul_req_fifo
  import mul_issue_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  mul_req_t din,
  output logic     full,
  output logic     empty,
  output mul_req_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  mul_req_t    mem_q [FIFO_DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q[AW-1:0]] <= din;
  end

  assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/mul_issue_arb.sv
// Two-port round-robin issue stage in front of the pipelined multiplier,
// with registered issue outputs and an in-flight occupancy counter.
module mul_issue_arb
  import mul_issue_arb_pkg::*;
#(
  parameter int M_WIDTH        = PKG_M_WIDTH,
  parameter int LG_ROB_ENTRIES = PKG_LG_ROB,
  parameter int LG_PRF_ENTRIES = PKG_LG_PRF,
  parameter int MUL_LAT        = 2,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       flush,
  input  logic [NUM_MUL_PORTS-1:0]                   req_valid,
  output logic [NUM_MUL_PORTS-1:0]                   req_ready,
  input  logic [NUM_MUL_PORTS-1:0]                   req_is_signed,
  input  logic [NUM_MUL_PORTS-1:0]                   req_is_high,
  input  logic [NUM_MUL_PORTS-1:0]                   req_is_mulw,
  input  logic [NUM_MUL_PORTS*M_WIDTH-1:0]           req_src_A,
  input  logic [NUM_MUL_PORTS*M_WIDTH-1:0]           req_src_B,
  input  logic [NUM_MUL_PORTS*LG_ROB_ENTRIES-1:0]    req_rob_ptr,
  input  logic [NUM_MUL_PORTS*LG_PRF_ENTRIES-1:0]    req_prf_ptr,
  output logic                                       mul_go,
  output logic                                       mul_is_signed,
  output logic                                       mul_is_high,
  output logic                                       mul_is_mulw,
  output logic [M_WIDTH-1:0]                         mul_src_A,
  output logic [M_WIDTH-1:0]                         mul_src_B,
  output logic [LG_ROB_ENTRIES-1:0]                  mul_rob_ptr,
  output logic [LG_PRF_ENTRIES-1:0]                  mul_prf_ptr,
  input  logic                                       mul_complete,
  output logic [$clog2(MUL_LAT+3)-1:0]               inflight,
  output logic                                       grant_port
);

  localparam int             IW      = $clog2(MUL_LAT + 3);
  localparam logic [IW-1:0]  INF_MAX = IW'(MUL_LAT + 2);

  mul_req_t                 req_s  [NUM_MUL_PORTS];
  mul_req_t                 head_s [NUM_MUL_PORTS];
  logic [NUM_MUL_PORTS-1:0] push, pop, full, empty, cand;
  logic                     issue, gnt;

  logic          rr_q, rr_d;
  logic          go_q, go_d;
  logic          gp_q, gp_d;
  mul_req_t      op_q, op_d;
  logic [IW-1:0] inf_q, inf_d;

  for (genvar i = 0; i < NUM_MUL_PORTS; i++) begin : g_port
    assign req_s[i] = '{
      is_signed: req_is_signed[i],
      is_high:   req_is_high[i],
      is_mulw:   req_is_mulw[i],
      src_A:     req_src_A[i*M_WIDTH +: M_WIDTH],
      src_B:     req_src_B[i*M_WIDTH +: M_WIDTH],
      rob_ptr:   req_rob_ptr[i*LG_ROB_ENTRIES +: LG_ROB_ENTRIES],
      prf_ptr:   req_prf_ptr[i*LG_PRF_ENTRIES +: LG_PRF_ENTRIES]
    };

    mul_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (req_s[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head_s[i])
    );
  end

  // Ready comes only from FIFO state, so a full FIFO never accepts even while popping.
  assign req_ready = ~full;
  assign push      = req_valid & ~full;

  always_comb begin
    cand  = ~empty;
    gnt   = rr_pick(cand, rr_q);
    issue = (|cand) && !flush;
    pop   = '0;
    rr_d  = rr_q;
    go_d  = issue;
    op_d  = op_q;
    gp_d  = gp_q;
    if (issue) begin
      pop[gnt] = 1'b1;
      rr_d     = ~gnt;
      op_d     = head_s[gnt];
      gp_d     = gnt;
    end
  end

  always_comb begin
    inf_d = inf_q;
    unique case ({go_q, mul_complete})
      2'b10:   if (inf_q != INF_MAX) inf_d = inf_q + 1'b1;
      2'b01:   if (inf_q != '0)      inf_d = inf_q - 1'b1;
      default: inf_d = inf_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q  <= 1'b0;
      go_q  <= 1'b0;
      gp_q  <= 1'b0;
      op_q  <= '0;
      inf_q <= '0;
    end else begin
      rr_q  <= rr_d;
      go_q  <= go_d;
      gp_q  <= gp_d;
      op_q  <= op_d;
      inf_q <= inf_d;
    end
  end

  // The count should never need to saturate; doing so means lost or phantom completions.
  assert property (@(posedge clk) disable iff (reset) !(go_q && !mul_complete && inf_q == INF_MAX));
  assert property (@(posedge clk) disable iff (reset) !(mul_complete && !go_q && inf_q == '0));

  assign mul_go        = go_q;
  assign mul_is_signed = op_q.is_signed;
  assign mul_is_high   = op_q.is_high;
  assign mul_is_mulw   = op_q.is_mulw;
  assign mul_src_A     = op_q.src_A;
  assign mul_src_B     = op_q.src_B;
  assign mul_rob_ptr   = op_q.rob_ptr;
  assign mul_prf_ptr   = op_q.prf_ptr;
  assign grant_port    = gp_q;
  assign inflight      = inf_q;

endmodule

// File: tb/tb_mul_issue_arb.sv
// Bench for mul_issue_arb: hand-built vector table, directed sequences and
// random traffic checked against a queue-based model of the issue rules.
module tb_mul_issue_arb;
  import mul_issue_arb_pkg::*;

  localparam int MW  = 64;
  localparam int RW  = 6;
  localparam int PW  = 7;
  localparam int LAT = 2;
  localparam int IW  = $clog2(LAT + 3);

  logic clk = 1'b0;
  logic reset, flush, mul_complete;
  logic [1:0] req_valid, req_ready;
  mul_req_t rq [2];
  logic [2*MW-1:0] req_src_A, req_src_B;
  logic [2*RW-1:0] req_rob_ptr;
  logic [2*PW-1:0] req_prf_ptr;
  logic [1:0] req_is_signed, req_is_high, req_is_mulw;
  logic mul_go, mul_is_signed, mul_is_high, mul_is_mulw, grant_port;
  logic [MW-1:0] mul_src_A, mul_src_B;
  logic [RW-1:0] mul_rob_ptr;
  logic [PW-1:0] mul_prf_ptr;
  logic [IW-1:0] inflight;
  mul_req_t d_op;

  always #5 clk = ~clk;

  assign req_is_signed = {rq[1].is_signed, rq[0].is_signed};
  assign req_is_high   = {rq[1].is_high, rq[0].is_high};
  assign req_is_mulw   = {rq[1].is_mulw, rq[0].is_mulw};
  assign req_src_A     = {rq[1].src_A, rq[0].src_A};
  assign req_src_B     = {rq[1].src_B, rq[0].src_B};
  assign req_rob_ptr   = {rq[1].rob_ptr, rq[0].rob_ptr};
  assign req_prf_ptr   = {rq[1].prf_ptr, rq[0].prf_ptr};
  assign d_op = '{is_signed: mul_is_signed, is_high: mul_is_high, is_mulw: mul_is_mulw,
                  src_A: mul_src_A, src_B: mul_src_B, rob_ptr: mul_rob_ptr, prf_ptr: mul_prf_ptr};

  mul_issue_arb #(.M_WIDTH(MW), .LG_ROB_ENTRIES(RW), .LG_PRF_ENTRIES(PW),
                  .MUL_LAT(LAT), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_signed(req_is_signed), .req_is_high(req_is_high), .req_is_mulw(req_is_mulw),
    .req_src_A(req_src_A), .req_src_B(req_src_B),
    .req_rob_ptr(req_rob_ptr), .req_prf_ptr(req_prf_ptr),
    .mul_go(mul_go), .mul_is_signed(mul_is_signed), .mul_is_high(mul_is_high),
    .mul_is_mulw(mul_is_mulw), .mul_src_A(mul_src_A), .mul_src_B(mul_src_B),
    .mul_rob_ptr(mul_rob_ptr), .mul_prf_ptr(mul_prf_ptr),
    .mul_complete(mul_complete), .inflight(inflight), .grant_port(grant_port)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  mul_req_t mq [2][$];
  bit       m_rr, m_go, m_gp;
  mul_req_t m_op;
  int       m_inf;
  bit [2:0] hist;
  bit       auto_cmp;
  bit       saw_full1;
  bit       lg_go [$];
  bit       lg_gp [$];
  logic [RW-1:0] lg_rob [$];
  int       lg_inf [$];

  task automatic model_edge();
    bit [1:0] rdy;
    int g;
    if (reset) begin
      mq[0].delete(); mq[1].delete();
      m_rr = 0; m_go = 0; m_gp = 0; m_op = '0; m_inf = 0; hist = '0;
      return;
    end
    hist  = {hist[1:0], m_go};
    m_inf = m_inf + int'(m_go) - int'(mul_complete);
    if (m_inf < 0) m_inf = 0;
    if (m_inf > LAT + 2) m_inf = LAT + 2;
    for (int i = 0; i < 2; i++) rdy[i] = (mq[i].size() < 2);
    if (flush) begin
      mq[0].delete(); mq[1].delete();
      m_go = 0;
      return;
    end
    g = -1;
    if (mq[0].size() > 0 && mq[1].size() > 0) g = int'(m_rr);
    else if (mq[0].size() > 0) g = 0;
    else if (mq[1].size() > 0) g = 1;
    m_go = (g >= 0);
    if (m_go) begin
      m_op = mq[g].pop_front();
      m_gp = (g == 1);
      m_rr = (g == 0);
    end
    for (int i = 0; i < 2; i++)
      if (req_valid[i] && rdy[i]) mq[i].push_back(rq[i]);
  endtask

  task automatic cycle();
    bit [1:0] er;
    if (auto_cmp) mul_complete = hist[2];
    er[0] = (mq[0].size() < 2);
    er[1] = (mq[1].size() < 2);
    chk("ready", req_ready, er);
    chk("go", mul_go, m_go);
    chk("op_fields", d_op, m_op);
    chk("grant_port", grant_port, m_gp);
    chk("inflight", inflight, m_inf);
    lg_go.push_back(mul_go);
    lg_gp.push_back(grant_port);
    lg_rob.push_back(mul_rob_ptr);
    lg_inf.push_back(int'(inflight));
    if (req_ready[1] === 1'b0) saw_full1 = 1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; flush = 0; req_valid = '0;
    @(posedge clk);
    model_edge();
    #1;
    reset = 0;
  endtask

  task automatic clear_logs();
    lg_go.delete(); lg_gp.delete(); lg_rob.delete(); lg_inf.delete();
    saw_full1 = 0;
  endtask

  function automatic mul_req_t rnd_req(input logic [RW-1:0] tag);
    mul_req_t r;
    {r.is_signed, r.is_high, r.is_mulw} = 3'($urandom);
    r.src_A   = {$urandom, $urandom};
    r.src_B   = {$urandom, $urandom};
    r.rob_ptr = tag;
    r.prf_ptr = PW'($urandom);
    return r;
  endfunction

  task automatic go_stats(output int first, output int run, output int tot);
    first = -1; run = 0; tot = 0;
    foreach (lg_go[k]) begin
      if (lg_go[k]) begin
        tot++;
        if (first < 0) first = k;
      end
    end
    if (first >= 0)
      for (int k = first; k < lg_go.size() && lg_go[k]; k++) run++;
  endtask

  // Port0 tags are 0.., port1 tags 32..; valid held while ops remain, advancing on acceptance.
  task automatic stream(input int n0, input int n1, input int idle);
    int sent [2];
    int n [2];
    bit acc [2];
    int guard;
    n[0] = n0; n[1] = n1; sent[0] = 0; sent[1] = 0; guard = 0;
    clear_logs();
    for (int i = 0; i < 2; i++) rq[i] = rnd_req(RW'(i * 32));
    while ((sent[0] < n0 || sent[1] < n1) && guard < 200) begin
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = (sent[i] < n[i]);
        acc[i] = req_valid[i] && (mq[i].size() < 2);
      end
      cycle();
      for (int i = 0; i < 2; i++)
        if (acc[i]) begin
          sent[i]++;
          rq[i] = rnd_req(RW'(i * 32 + sent[i]));
        end
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d cycles expected < 200", guard);
    end
    req_valid = '0;
    repeat (idle) cycle();
  endtask

  typedef struct packed {
    logic       v0;
    logic       cmp;
    logic [1:0] rdy;
    logic       go;
    logic       gp;
    logic [2:0] inf;
    logic       data;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t     tv [8];
    mul_req_t one;
    int first, run, tot, n3, bad;
    int cnt [64];

    one = '{is_signed: 1'b1, is_high: 1'b0, is_mulw: 1'b0, src_A: -64'sd3, src_B: 64'd5,
            rob_ptr: 6'd4, prf_ptr: 7'd9};
    //          v0    cmp   rdy    go    gp    inf   data
    tv[0] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0};
    tv[2] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0};
    tv[3] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 3'd0, 1'b1};
    tv[4] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd1, 1'b1};
    tv[5] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd1, 1'b1};
    tv[6] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 3'd1, 1'b1};
    tv[7] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 1'b1};

    m_rr = 0; m_go = 0; m_gp = 0; m_op = '0; m_inf = 0; hist = '0;
    auto_cmp = 0; mul_complete = 0; flush = 0; req_valid = '0;
    rq[0] = '0; rq[1] = '0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    chk("reset_op_fields", d_op, '0);
    chk("reset_grant_port", grant_port, 1'b0);

    // Single op through the table
    rq[0] = one;
    for (int r = 0; r < 8; r++) begin
      req_valid    = {1'b0, tv[r].v0};
      mul_complete = tv[r].cmp;
      chk($sformatf("tv%0d_ready", r), req_ready, tv[r].rdy);
      chk($sformatf("tv%0d_go", r), mul_go, tv[r].go);
      chk($sformatf("tv%0d_gp", r), grant_port, tv[r].gp);
      chk($sformatf("tv%0d_inflight", r), inflight, tv[r].inf);
      if (tv[r].data) chk($sformatf("tv%0d_op", r), d_op, one);
      @(posedge clk);
      #1;
    end

    auto_cmp = 1;
    mul_complete = 0;

    // Contention: 4 ops per port, strict alternation with no bubbles
    do_reset();
    stream(4, 4, 8);
    go_stats(first, run, tot);
    chk("cont_latency", first, 2);
    chk("cont_total", tot, 8);
    chk("cont_run", run, 8);
    for (int k = 0; k < 8; k++)
      if (first >= 0 && first + k < lg_gp.size())
        chk($sformatf("cont_gp%0d", k), lg_gp[first + k], k % 2);

    // Backpressure on port1 with rob_ptr scoreboard
    do_reset();
    stream(6, 6, 10);
    chk("bp_port1_full_seen", saw_full1, 1'b1);
    for (int t = 0; t < 64; t++) cnt[t] = 0;
    foreach (lg_go[k]) if (lg_go[k]) cnt[lg_rob[k]]++;
    bad = 0;
    for (int t = 0; t < 64; t++)
      if (cnt[t] != (((t < 6) || (t >= 32 && t < 38)) ? 1 : 0)) bad++;
    go_stats(first, run, tot);
    chk("bp_total", tot, 12);
    chk("bp_scoreboard_bad_tags", bad, 0);

    // One port at full rate: go and complete overlap, inflight holds at 3
    do_reset();
    stream(12, 0, 8);
    go_stats(first, run, tot);
    chk("p0_stream_run", run, 12);
    n3 = 0;
    foreach (lg_inf[k]) if (lg_inf[k] == 3) n3++;
    chk("sat_inflight3_cycles", n3, 10);

    // Flush with queued and staged work
    do_reset();
    req_valid = 2'b11;
    rq[0] = rnd_req(6'd1);
    rq[1] = rnd_req(6'd33);
    repeat (3) cycle();
    chk("flush_staged_go", mul_go, 1'b1);
    flush = 1;
    cycle();
    flush = 0;
    req_valid = '0;
    chk("flush_go_next", mul_go, 1'b0);
    chk("flush_ready", req_ready, 2'b11);
    clear_logs();
    repeat (12) cycle();
    go_stats(first, run, tot);
    chk("flush_no_go", tot, 0);
    chk("flush_inflight_drain", inflight, 0);

    // Reset mid-stream with the RR pointer away from port 0
    do_reset();
    req_valid = 2'b11;
    rq[0] = rnd_req(6'd2);
    rq[1] = rnd_req(6'd34);
    cycle();
    req_valid = '0;
    cycle();
    reset = 1;
    req_valid = 2'b11;
    cycle();
    reset = 0;
    chk("rst_mid_ready", req_ready, 2'b11);
    chk("rst_mid_go", mul_go, 1'b0);
    chk("rst_mid_inflight", inflight, 0);
    clear_logs();
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    go_stats(first, run, tot);
    if (first >= 0) chk("rst_first_gp", lg_gp[first], 1'b0);
    else chk("rst_first_go_seen", tot, 2);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        rq[i] = rnd_req(RW'($urandom));
      end
      cycle();
    end
    reset = 0; flush = 0; req_valid = '0;
    repeat (12) cycle();
    chk("rand_inflight_drain", inflight, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
